bitwise_logic_unit: RTL
=======================

// Module: bitwise_logic_unit
// PURPOSE
//   Parametrised, registered two-operand bitwise logic unit: one of eight ops (AND, ~A&B, OR, XOR,
//   NAND, NOR, XNOR, ~A) on WIDTH-bit operands, with a valid/ready stream in and out.
//   Built-in SWEEP mode drives every (a,b) pair through the selected op, for truth-table self-check.
//   Replaces the fixed 1-bit gate modules in the lab datapath exercises.
// PARAMETERS
//   WIDTH     4   operand/result width in bits (1..8; sweep length is 2^(2*WIDTH))
//   SWEEP_EN  1   1 = sweep FSM present; 0 = sweep_start ignored, sweep_busy/sweep_done tied 0
// PORTS
//   clk          in   1      single clock, all state on rising edge
//   reset        in   1      synchronous, active-high
//   in_valid     in   1      a/b/op valid this cycle
//   in_ready     out  1      unit accepts when in_valid & in_ready
//   a            in   WIDTH  operand A
//   b            in   WIDTH  operand B
//   op           in   3      operation select (codes in package)
//   sweep_start  in   1      one-cycle pulse: start sweep using current op (latched)
//   out_valid    out  1      s/zero/ones valid
//   out_ready    in   1      consumer takes result when out_valid & out_ready
//   s            out  WIDTH  result
//   zero         out  1      s == 0
//   ones         out  1      s == all ones
//   sweep_busy   out  1      sweep in progress
//   sweep_done   out  1      one-cycle pulse after last sweep result is accepted downstream
// BEHAVIOUR
//   Reset: in_ready=0 in reset cycle, then 1; out_valid=0, s=0, zero=0, ones=0, sweep_busy=0,
//     sweep_done=0; skid buffer emptied; FSM -> IDLE. Reset mid-sweep/mid-transfer discards all data.
//   Ops: AND a&b; ANDN ~a&b; OR a|b; XOR a^b; NAND ~(a&b); NOR ~(a|b); XNOR ~(a^b); NOTA ~a (b ignored).
//   zero/ones computed from registered s, valid only with out_valid; else held 0.
//   Latency: accepted input -> out_valid exactly 1 cycle later if output not stalled.
//   Throughput: 1 result/cycle with out_ready=1. 2-entry skid buffer: in_ready = buffer not full,
//     registered (no combinational out_ready->in_ready path). Stall holds s/zero/ones stable.
//   Order: results strictly in acceptance order; no drop, no duplicate.
//   FSM (SWEEP_EN=1): IDLE --sweep_start & buffer empty--> SWEEP; sweep_start otherwise ignored.
//     SWEEP: in_ready=0 (external in_valid ignored); counter c (2*WIDTH bits) from 0;
//       a=c[2W-1:W], b=c[W-1:0], op=latched op; issues one item per cycle when buffer has room;
//       after item c = 2^(2W)-1 is issued -> DRAIN.
//     DRAIN: waits for buffer empty, pulses sweep_done 1 cycle -> IDLE. sweep_busy=1 in SWEEP/DRAIN.
//   sweep_start coincident with an in_valid&in_ready handshake: external item accepted, sweep
//     not started (buffer non-empty next cycle).
//   Counter wrap 2^(2W)-1 -> 0 never observed; FSM leaves SWEEP on the last item.
// STRUCTURE
//   Package logic_unit_pkg: localparams OP_AND=3'd0, OP_ANDN=3'd1, OP_OR=3'd2, OP_XOR=3'd3,
//     OP_NAND=3'd4, OP_NOR=3'd5, OP_XNOR=3'd6, OP_NOTA=3'd7; FSM encodings IDLE/SWEEP/DRAIN;
//     function logic_op(op,a,b) shared with bench reference model.
//   Sub-module logic_skid_buffer #(DW): 2-entry valid/ready buffer carrying {s}, flags derived at output.
//   Top: input mux (external vs sweep), op function, register into skid buffer, sweep FSM.
// TESTING
//   1 Reset: reset=1 two cycles -> all outputs 0; cycle after release in_ready=1.
//   2 WIDTH=4, op=ANDN, a=4'b0011, b=4'b0101, out_ready=1 -> next cycle out_valid=1, s=4'b0100,
//     zero=0, ones=0; op=XNOR same operands -> s=4'b1001.
//   3 Back-pressure: out_ready=0, push 3 items -> 2 accepted, in_ready=0; raise out_ready ->
//     outputs in order, s stable while stalled, no loss.
//   4 Sweep, WIDTH=2, op=AND: pulse sweep_start -> 16 results, a/b pairs 0..15 in order, s=a&b;
//     sweep_done one cycle after 16th accept; in_ready=0 throughout sweep_busy.
//   5 Sweep start ignored while buffer non-empty or with simultaneous input handshake -> sweep_busy stays 0.
//   6 Reset asserted mid-sweep (after 5 items) -> next cycle out_valid=0, sweep_busy=0, no sweep_done.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared op codes, sweep FSM encoding and the bitwise op function for the logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned MAX_WIDTH = 8;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_NOTA = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } sweep_state_e;

  // Operands are zero-extended by the caller; upper result bits are discarded.
  function automatic logic [MAX_WIDTH-1:0] logic_op(input logic [OP_W-1:0] op,
                                                    input logic [MAX_WIDTH-1:0] a,
                                                    input logic [MAX_WIDTH-1:0] b);
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_ANDN: r = ~a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_skid_buffer.sv
// Two-entry valid/ready buffer with registered ready; zero/ones flags are registered with the head.
module logic_skid_buffer #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          zero,
  output logic          ones,
  output logic          empty,
  output logic          empty_next_c
);

  logic          head_v_q, head_v_d;
  logic          skid_v_q, skid_v_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          ready_q, zero_q, ones_q;
  logic          push, pop;

  assign push = in_valid & ready_q;
  assign pop  = head_v_q & out_ready;

  // Head refills from the skid slot first so acceptance order is preserved.
  always_comb begin
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    head_d   = head_q;
    skid_d   = skid_q;
    if (!head_v_q || pop) begin
      if (skid_v_q) begin
        head_v_d = 1'b1;
        head_d   = skid_q;
        skid_v_d = push;
        if (push) skid_d = in_data;
      end else begin
        head_v_d = push;
        if (push) head_d = in_data;
      end
    end else if (push) begin
      skid_v_d = 1'b1;
      skid_d   = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
      ready_q  <= 1'b0;
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
    end else begin
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      ready_q  <= ~skid_v_d;
      zero_q   <= head_v_d && (head_d == '0);
      ones_q   <= head_v_d && (head_d == '1);
    end
  end

  assign in_ready     = ready_q;
  assign out_valid    = head_v_q;
  assign out_data     = head_q;
  assign zero         = zero_q;
  assign ones         = ones_q;
  assign empty        = ~head_v_q & ~skid_v_q;
  assign empty_next_c = ~head_v_d & ~skid_v_d;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered two-operand bitwise logic unit with valid/ready streams and a truth-table sweep mode.
module bitwise_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SWEEP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             sweep_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             ones,
  output logic             sweep_busy,
  output logic             sweep_done
);

  localparam int unsigned CW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_MAX = '1;

  sweep_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic          busy_q, done_q;

  logic             sweeping, buf_in_valid, buf_ready, buf_empty, buf_empty_next;
  logic             ext_fire, issue;
  logic [WIDTH-1:0] a_sel, b_sel, result;
  logic [2:0]       op_sel;

  assign sweeping = (state_q == ST_SWEEP);
  assign in_ready = buf_ready & ~busy_q;
  assign ext_fire = in_valid & in_ready;
  assign issue    = sweeping & buf_ready;

  // Sweep counter supplies {a,b} while sweeping; external operands otherwise.
  assign a_sel  = sweeping ? cnt_q[CW-1:WIDTH] : a;
  assign b_sel  = sweeping ? cnt_q[WIDTH-1:0]  : b;
  assign op_sel = sweeping ? op_q : op;
  assign result = WIDTH'(logic_op(op_sel, MAX_WIDTH'(a_sel), MAX_WIDTH'(b_sel)));

  assign buf_in_valid = sweeping | (in_valid & ~busy_q);

  logic_skid_buffer #(.DW(WIDTH)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (buf_in_valid),
    .in_ready     (buf_ready),
    .in_data      (result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (s),
    .zero         (zero),
    .ones         (ones),
    .empty        (buf_empty),
    .empty_next_c (buf_empty_next)
  );

  // Sweep sequencer: done pulses in the cycle after the last sweep result leaves the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_AND;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (SWEEP_EN && sweep_start && buf_empty && !ext_fire) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            op_q    <= op;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (issue) begin
            if (cnt_q == CNT_MAX) state_q <= ST_DRAIN;
            else                  cnt_q   <= cnt_q + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (buf_empty_next) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_busy = busy_q;
  assign sweep_done = done_q;

endmodule
